// File: rtl/cross_bar_slave_mem_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cross_bar_slave_mem_if
//  Description : req/addr/cmd/wdata -> ack/rdata handshake between a crossbar
//                master port and a slave endpoint.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cross_bar_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              slave_req;
    logic [ADDR_W-1:0] slave_addr;
    logic              slave_cmd;
    logic [DATA_W-1:0] slave_wdata;
    logic              slave_ack;
    logic [DATA_W-1:0] slave_rdata;

    modport master (
        output slave_req, slave_addr, slave_cmd, slave_wdata,
        input  slave_ack, slave_rdata
    );

    modport slave (
        input  slave_req, slave_addr, slave_cmd, slave_wdata,
        output slave_ack, slave_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cross_bar_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cross_bar_slave_mem
//  Description : Memory-backed crossbar slave with fixed ack latency, address
//                range / protocol error pulses and read/write counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cross_bar_slave_mem #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              MEM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              LATENCY   = 2
) (
    input  wire logic              clk,
    input  wire logic              areset,
    cross_bar_slave_mem_if.slave   bus,
    output logic                   addr_err,
    output logic                   proto_err,
    output logic [15:0]            wr_cnt,
    output logic [15:0]            rd_cnt
);

    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                cmd_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                inr_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                addr_err_q, addr_err_d;
    logic                proto_err_q, proto_err_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_word;
    logic                w_in_range;
    logic                w_latch;
    logic                w_abort;
    logic                w_cmd;
    logic [IDX_W-1:0]    w_idx;
    logic                w_inr;
    logic                w_we;

    // Offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land far out of range.
    assign w_off      = bus.slave_addr - BASE_ADDR;
    assign w_word     = w_off >> BYTE_SHIFT;
    assign w_in_range = (w_word < ADDR_W'(MEM_DEPTH)) && ((w_word << BYTE_SHIFT) == w_off);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_latch = 1'b0;
        w_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.slave_req) begin
                    w_latch = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!bus.slave_req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    w_abort = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With LATENCY=1 the ACK cycle is entered straight from IDLE, so use the live request fields.
    assign w_cmd = w_latch ? bus.slave_cmd : cmd_q;
    assign w_idx = w_latch ? w_word[IDX_W-1:0] : idx_q;
    assign w_inr = w_latch ? w_in_range : inr_q;
    assign w_we  = (state_q == S_ACK) && cmd_q && inr_q;

    always_comb begin
        rdata_d     = '0;
        addr_err_d  = 1'b0;
        proto_err_d = w_abort;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        if (state_d == S_ACK) begin
            addr_err_d = !w_inr;
            if (!w_cmd && w_inr) begin
                rdata_d = mem[w_idx];
            end
        end
        if (state_q == S_ACK) begin
            if (cmd_q) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cmd_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            inr_q       <= 1'b0;
            rdata_q     <= '0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
            wr_cnt_q    <= 16'd0;
            rd_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            addr_err_q  <= addr_err_d;
            proto_err_q <= proto_err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            if (w_latch) begin
                cmd_q   <= bus.slave_cmd;
                idx_q   <= w_word[IDX_W-1:0];
                wdata_q <= bus.slave_wdata;
                inr_q   <= w_in_range;
            end
        end
    end

    // Storage is not reset; an asynchronous reset clears state_q, which blocks any pending commit.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.slave_ack   = (state_q == S_ACK);
    assign bus.slave_rdata = rdata_q;
    assign addr_err        = addr_err_q;
    assign proto_err       = proto_err_q;
    assign wr_cnt          = wr_cnt_q;
    assign rd_cnt          = rd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cross_bar_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cross_bar_slave_mem
//  Description : Directed bench for cross_bar_slave_mem; four instances cover
//                LATENCY 1/2/4/15 and a non-zero BASE_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cross_bar_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance map: 0 -> LAT1, 1 -> LAT2, 2 -> LAT4, 3 -> LAT15 with BASE_ADDR 0x1000
    logic [3:0]        rst_a;
    logic [3:0]        req;
    logic [3:0]        cmd;
    logic [3:0][31:0]  addr_a;
    logic [3:0][31:0]  wdata_a;
    logic [3:0]        ack;
    logic [3:0][31:0]  rdata_a;
    logic [3:0]        aerr;
    logic [3:0]        perr;
    logic [3:0][15:0]  wrc;
    logic [3:0][15:0]  rdc;

    int n_assert = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int          LAT  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 15;
        localparam logic [31:0] BASE = (g == 3) ? 32'h0000_1000 : 32'h0;

        cross_bar_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        assign bus.slave_req   = req[g];
        assign bus.slave_cmd   = cmd[g];
        assign bus.slave_addr  = addr_a[g];
        assign bus.slave_wdata = wdata_a[g];
        assign ack[g]          = bus.slave_ack;
        assign rdata_a[g]      = bus.slave_rdata;

        cross_bar_slave_mem #(
            .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .BASE_ADDR(BASE), .LATENCY(LAT)
        ) u_dut (
            .clk       (clk),
            .areset    (rst_a[g]),
            .bus       (bus),
            .addr_err  (aerr[g]),
            .proto_err (perr[g]),
            .wr_cnt    (wrc[g]),
            .rd_cnt    (rdc[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one transaction and waits for its ack; keep holds req high into the next one.
    task automatic txn(input int d, input logic c, input logic [31:0] a, input logic [31:0] wd,
                       input int exp_cyc, input logic [31:0] exp_rd, input logic exp_ae,
                       input logic keep);
        int n;
        n          = 0;
        req[d]     = 1'b1;
        cmd[d]     = c;
        addr_a[d]  = a;
        wdata_a[d] = wd;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack[d] && n < 40);
        chk("ack_latency", 32'(n), 32'(exp_cyc));
        if (!c) chk("rdata_at_ack", rdata_a[d], exp_rd);
        chk("addr_err_at_ack", {31'd0, aerr[d]}, {31'd0, exp_ae});
        if (!keep) begin
            req[d] = 1'b0;
            @(posedge clk); #1;
            chk("ack_single_cycle", {31'd0, ack[d]}, 32'd0);
            chk("rdata_zero_after_ack", rdata_a[d], 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a   = 4'hF;
        req     = '0;
        cmd     = '0;
        addr_a  = '0;
        wdata_a = '0;
        repeat (3) @(posedge clk);
        #1 rst_a = 4'h0;

        // Reset state
        chk("rst_ack",       {31'd0, ack[1]},  32'd0);
        chk("rst_rdata",     rdata_a[1],       32'd0);
        chk("rst_addr_err",  {31'd0, aerr[1]}, 32'd0);
        chk("rst_proto_err", {31'd0, perr[1]}, 32'd0);
        chk("rst_wr_cnt",    {16'd0, wrc[1]},  32'd0);
        chk("rst_rd_cnt",    {16'd0, rdc[1]},  32'd0);

        // Basic write/read, LATENCY=2
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1'b0);
        txn(1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("basic_wr_cnt", {16'd0, wrc[1]}, 32'd1);
        chk("basic_rd_cnt", {16'd0, rdc[1]}, 32'd1);

        // LATENCY=1
        txn(0, 1'b1, 32'h0, 32'h12345678, 1, 32'h0, 1'b0, 1'b0);
        txn(0, 1'b0, 32'h0, 32'h0, 1, 32'h12345678, 1'b0, 1'b0);
        chk("lat1_wr_cnt", {16'd0, wrc[0]}, 32'd1);
        chk("lat1_rd_cnt", {16'd0, rdc[0]}, 32'd1);

        // LATENCY=15 with BASE_ADDR=0x1000: last word, then out-of-range cases
        txn(3, 1'b1, 32'h13FC, 32'h77, 15, 32'h0, 1'b0, 1'b0);
        txn(3, 1'b0, 32'h13FC, 32'h0, 15, 32'h77, 1'b0, 1'b0);
        txn(3, 1'b1, 32'h0FFC, 32'h55, 15, 32'h0, 1'b1, 1'b0);
        txn(3, 1'b0, 32'h1400, 32'h0, 15, 32'h0, 1'b1, 1'b0);
        txn(3, 1'b0, 32'h1002, 32'h0, 15, 32'h0, 1'b1, 1'b0);
        txn(3, 1'b0, 32'h13FC, 32'h0, 15, 32'h77, 1'b0, 1'b0);
        chk("oor_wr_cnt", {16'd0, wrc[3]}, 32'd2);
        chk("oor_rd_cnt", {16'd0, rdc[3]}, 32'd4);

        // Back-to-back on LATENCY=2: req stays high across eight transactions
        txn(1, 1'b1, 32'h0, 32'd1, 2, 32'h0, 1'b0, 1'b1);
        txn(1, 1'b1, 32'h4, 32'd2, 3, 32'h0, 1'b0, 1'b1);
        txn(1, 1'b1, 32'h8, 32'd3, 3, 32'h0, 1'b0, 1'b1);
        txn(1, 1'b1, 32'hC, 32'd4, 3, 32'h0, 1'b0, 1'b1);
        txn(1, 1'b0, 32'h0, 32'h0, 3, 32'd1, 1'b0, 1'b1);
        txn(1, 1'b0, 32'h4, 32'h0, 3, 32'd2, 1'b0, 1'b1);
        txn(1, 1'b0, 32'h8, 32'h0, 3, 32'd3, 1'b0, 1'b1);
        txn(1, 1'b0, 32'hC, 32'h0, 3, 32'd4, 1'b0, 1'b0);
        chk("b2b_wr_cnt", {16'd0, wrc[1]}, 32'd5);
        chk("b2b_rd_cnt", {16'd0, rdc[1]}, 32'd5);

        // Protocol error on LATENCY=4: req dropped two cycles after accept
        txn(2, 1'b1, 32'h20, 32'h11, 4, 32'h0, 1'b0, 1'b0);
        req[2] = 1'b1; cmd[2] = 1'b1; addr_a[2] = 32'h20; wdata_a[2] = 32'h99;
        @(posedge clk); #1;
        chk("perr_wait_ack0", {31'd0, ack[2]}, 32'd0);
        @(posedge clk); #1;
        chk("perr_wait_ack1", {31'd0, ack[2]}, 32'd0);
        req[2] = 1'b0;
        @(posedge clk); #1;
        chk("perr_pulse",    {31'd0, perr[2]}, 32'd1);
        chk("perr_no_ack",   {31'd0, ack[2]},  32'd0);
        @(posedge clk); #1;
        chk("perr_one_cycle", {31'd0, perr[2]}, 32'd0);
        chk("perr_no_ack2",   {31'd0, ack[2]},  32'd0);
        chk("perr_wr_cnt",    {16'd0, wrc[2]},  32'd1);
        chk("perr_rd_cnt",    {16'd0, rdc[2]},  32'd0);
        txn(2, 1'b0, 32'h20, 32'h0, 4, 32'h11, 1'b0, 1'b0);

        // Reset two cycles into a LATENCY=4 write of 0xAA
        req[2] = 1'b1; cmd[2] = 1'b1; addr_a[2] = 32'h20; wdata_a[2] = 32'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_a[2] = 1'b1;
        req[2]   = 1'b0;
        #1;
        chk("rst_mid_ack",    {31'd0, ack[2]}, 32'd0);
        chk("rst_mid_wr_cnt", {16'd0, wrc[2]}, 32'd0);
        chk("rst_mid_rd_cnt", {16'd0, rdc[2]}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_ack", {31'd0, ack[2]}, 32'd0);
        end
        rst_a[2] = 1'b0;
        txn(2, 1'b0, 32'h20, 32'h0, 4, 32'h11, 1'b0, 1'b0);
        chk("post_rst_rd_cnt", {16'd0, rdc[2]}, 32'd1);
        chk("post_rst_wr_cnt", {16'd0, wrc[2]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
